// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: the MEM->WB bundle
// layout, the GPR forward bundle, and the exception/CSR codes the stage uses.
package wb_stage_pkg;

  localparam int MEM2WB_W = 167;
  localparam int WB_RF_W  = 38;

  localparam logic [5:0]  ECODE_INT  = 6'h00;
  localparam logic [5:0]  ECODE_SYS  = 6'h0b;
  localparam logic [5:0]  ECODE_BRK  = 6'h0c;
  localparam logic [5:0]  ECODE_INE  = 6'h0d;
  localparam logic [8:0]  ESUBCODE_ADEF = 9'h000;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000c;

  // MSB-first field order of mem_to_wb_zip; packed struct puts the first
  // member at the top, so a straight cast lines the fields up.
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } mem2wb_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_rf_t;

endpackage

// File: rtl/wb_instret_cnt.sv
// Retired-instruction counter: clears on reset, steps by one on inc and
// rolls over naturally at the top of its range.
module wb_instret_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count retirements; natural binary wrap from all-ones back to zero
  always_ff @(posedge clk) begin
    if (!resetn)  cnt <= '0;
    else if (inc) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds the last MEM instruction for one cycle, commits
// its GPR/CSR writes, raises the global flush on exception or ertn, and
// drives the trace port and retired-instruction count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int MEM2WB_LEN = MEM2WB_W,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_to_wb_valid,
  input  logic [MEM2WB_LEN-1:0] mem_to_wb_zip,
  output logic                  wb_allowin,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [13:0]           csr_num,
  input  logic [31:0]           csr_rvalue,
  output logic                  csr_we,
  output logic [31:0]           csr_wmask,
  output logic [31:0]           csr_wvalue,
  output logic                  wb_ex,
  output logic [5:0]            wb_ecode,
  output logic [8:0]            wb_esubcode,
  output logic [31:0]           wb_era,
  output logic                  ertn_flush,
  input  logic [31:0]           csr_ex_entry,
  input  logic [31:0]           csr_era,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic [WB_RF_W-1:0]    wb_rf_zip,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata,
  output logic [CNT_W-1:0]      instret
);

  // WB never stalls today; ready_go stays as the hook for a future stall.
  localparam logic READY_GO = 1'b1;

  mem2wb_t in_bus;
  mem2wb_t wb_r;
  wb_rf_t  fwd;
  logic    wb_valid;
  logic    accept;
  logic    ex;
  logic    er;

  assign in_bus     = mem2wb_t'(mem_to_wb_zip);
  assign wb_allowin = ~wb_valid | READY_GO;
  assign accept     = mem_to_wb_valid & wb_allowin & ~flush;

  // occupancy: a flushing cycle discards whatever MEM is offering
  always_ff @(posedge clk) begin
    if (!resetn)    wb_valid <= 1'b0;
    else if (flush) wb_valid <= 1'b0;
    else            wb_valid <= mem_to_wb_valid & wb_allowin;
  end

  // payload capture; held when nothing is accepted
  always_ff @(posedge clk) begin
    if (!resetn)     wb_r <= '0;
    else if (accept) wb_r <= in_bus;
  end

  // exception has priority over ertn when both are tagged
  always_comb begin
    ex       = wb_valid & wb_r.ex_valid;
    er       = wb_valid & wb_r.is_ertn & ~wb_r.ex_valid;
    flush    = ex | er;
    flush_pc = ex ? csr_ex_entry : csr_era;
  end

  // commit side: faulting instructions suppress both GPR and CSR writes
  always_comb begin
    wb_ex       = ex;
    ertn_flush  = er;
    wb_ecode    = wb_r.ecode;
    wb_esubcode = wb_r.esubcode;
    wb_era      = wb_r.pc;
    csr_we      = wb_valid & wb_r.csr_we & ~wb_r.ex_valid;
    csr_num     = wb_r.csr_num;
    csr_wmask   = wb_r.csr_wmask;
    csr_wvalue  = wb_r.csr_wvalue;
    rf_we       = wb_valid & wb_r.rf_we & ~wb_r.ex_valid;
    rf_waddr    = wb_r.rf_waddr;
    rf_wdata    = wb_r.csr_read ? csr_rvalue : wb_r.rf_wdata;
  end

  // ID forward bundle and trace mirror the same-cycle GPR write
  always_comb begin
    fwd.we            = rf_we;
    fwd.waddr         = rf_waddr;
    fwd.wdata         = rf_wdata;
    wb_rf_zip         = fwd;
    debug_wb_pc       = wb_r.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

  wb_instret_cnt #(.CNT_W(CNT_W)) u_instret (
    .clk    (clk),
    .resetn (resetn),
    .inc    (wb_valid & ~wb_r.ex_valid),
    .cnt    (instret)
  );

endmodule
